router_pkt_src: RTL

// - Upstream packet source for the 1x3 router: buffers payload bytes, then on request streams one

---
 rtl/router_pkt_src.sv | 107 ++++++++++
 1 files changed

// File: rtl/router_pkt_src.sv
// router_pkt_src: buffers payload bytes and streams header/payload/parity packets to the 1x3 router.
// Optional ERR_INJECT_EN adds inj_err, which corrupts bit 0 of the parity byte of the packet it is sampled with.
module router_pkt_src #(
   parameter int DEPTH    = 64,
   parameter int IDLE_GAP = 2
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       pay_valid,
   input  logic [7:0] pay_data,
   output logic       pay_ready,
   input  logic       req_valid,
   input  logic [1:0] req_addr,
   input  logic [5:0] req_len,
   output logic       req_ready,
   output logic       req_err,
   input  logic       busy,
   output logic       pkt_valid,
   output logic [7:0] data_in,
   output logic       tx_done,
`ifdef ERR_INJECT_EN
   input  logic       inj_err,
`endif
   output logic [7:0] pkt_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int GW = $clog2(IDLE_GAP + 1);
   localparam logic [2:0] IDLE = 3'd0, HEADER = 3'd1, PAYLOAD = 3'd2, PARITY = 3'd3, GAP = 3'd4;

   logic [2:0]    state, state_n;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic [1:0]    addr_q;
   logic [5:0]    len_q, bcnt;
   logic [7:0]    acc;
   logic [GW-1:0] gcnt;
   logic          inj_q, push, pop, xfer, illegal, launch;

   assign illegal   = req_addr == 2'd3 || req_len == 6'd0;
   assign pay_ready = resetn && count < CW'(DEPTH);
   assign req_ready = state == IDLE && req_valid && (illegal || count >= CW'(req_len));
   assign launch    = req_ready && !illegal;
   assign xfer      = !busy && (state == HEADER || state == PAYLOAD || state == PARITY);
   assign push      = pay_valid && pay_ready;
   assign pop       = xfer && state == PAYLOAD;
   assign pkt_valid = state == HEADER || state == PAYLOAD;
   assign data_in   = state == HEADER  ? {len_q, addr_q} :
                      state == PAYLOAD ? mem[rd_ptr] :
                      state == PARITY  ? acc ^ {7'd0, inj_q} : 8'd0;

`ifdef ERR_INJECT_EN
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) inj_q <= 1'b0;
      else if (launch) inj_q <= inj_err;
`else
   assign inj_q = 1'b0;
`endif

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = launch ? HEADER : IDLE;
         HEADER:  state_n = xfer ? PAYLOAD : HEADER;
         PAYLOAD: state_n = xfer && bcnt == len_q - 6'd1 ? PARITY : PAYLOAD;
         PARITY:  state_n = xfer ? GAP : PARITY;
         GAP:     state_n = gcnt == GW'(IDLE_GAP - 1) ? IDLE : GAP;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= pay_data;

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         state   <= IDLE;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         addr_q  <= '0;
         len_q   <= '0;
         bcnt    <= '0;
         acc     <= '0;
         gcnt    <= '0;
         req_err <= 1'b0;
         tx_done <= 1'b0;
         pkt_cnt <= '0;
      end else begin
         state   <= state_n;
         wr_ptr  <= wr_ptr + AW'(push);
         rd_ptr  <= rd_ptr + AW'(pop);
         count   <= count + CW'(push) - CW'(pop);
         req_err <= req_ready && illegal;
         tx_done <= xfer && state == PARITY;
         pkt_cnt <= pkt_cnt + 8'(xfer && state == PARITY);
         bcnt    <= state == IDLE ? 6'd0 : bcnt + 6'(pop);
         gcnt    <= state == GAP ? gcnt + GW'(1) : '0;
         // Accumulator seeds with the header so the parity covers it too
         acc     <= launch ? {req_len, req_addr} : pop ? acc ^ mem[rd_ptr] : acc;
         if (launch) begin
            addr_q <= req_addr;
            len_q  <= req_len;
         end
      end
endmodule
